// File: rtl/fc_pkg.sv
// Shared constants and FSM encoding for the fully-connected parameter path.
// The MAC stage imports the packed vector widths from here as well.
package fc_pkg;

  localparam int FC_I_BW        = 8;
  localparam int FC_BIAS_BW     = 2 * FC_I_BW;
  localparam int FC_NUM_CLASSES = 3;
  localparam int FC_PKT_LEN     = 208;

  localparam int FC_W_VEC_BW = FC_NUM_CLASSES * FC_I_BW;
  localparam int FC_B_VEC_BW = FC_NUM_CLASSES * FC_BIAS_BW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fc_param_mem.sv
// Single-write-port weight RAM with a registered read port (1-cycle latency).
module fc_param_mem #(
  parameter int DEPTH   = 208,
  parameter int DATA_BW = 24,
  parameter int ADDR_BW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [DATA_BW-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [DATA_BW-1:0] rd_data
);

  logic [DATA_BW-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; callers
  // must never trust contents they have not written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fc_param_streamer.sv
// Streams one packet of per-class weight beats (valid/ready/last) and holds a
// static bias vector. Define FC_PARAM_AUTO_RESTART_EN to repeat packets forever.
module fc_param_streamer
  import fc_pkg::*;
#(
  parameter int I_BW        = FC_I_BW,
  parameter int BIAS_BW     = 2 * I_BW,
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int PKT_LEN     = FC_PKT_LEN,
  parameter int ADDR_BW     = $clog2(PKT_LEN)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  output logic                           busy_o,
  input  logic                           wr_en_i,
  input  logic [ADDR_BW-1:0]             wr_addr_i,
  input  logic [NUM_CLASSES*I_BW-1:0]    wr_data_i,
  input  logic                           bias_wr_en_i,
  input  logic [NUM_CLASSES*BIAS_BW-1:0] bias_data_i,
  output logic [NUM_CLASSES*I_BW-1:0]    data_w_o,
  output logic [NUM_CLASSES*BIAS_BW-1:0] data_b_o,
  output logic                           valid_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic                           err_o
);

  localparam int W_BW   = NUM_CLASSES * I_BW;
  localparam int B_BW   = NUM_CLASSES * BIAS_BW;
  localparam int MEM_AW = $clog2(PKT_LEN);
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(PKT_LEN - 1);

  fc_state_e          state;
  logic [ADDR_BW-1:0] rd_addr;
  logic               issue, pop, push, addr_ok, wr_commit;
  logic               inflight, inflight_last;
  logic [W_BW-1:0]    mem_rd_data;
  logic [W_BW-1:0]    fifo_data [2];
  logic [1:0]         fifo_last;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count, occ;
  logic [B_BW-1:0]    bias_q;

  assign valid_o  = (count != 2'd0);
  assign data_w_o = fifo_data[rd_ptr];
  assign last_o   = fifo_last[rd_ptr];
  assign data_b_o = bias_q;

  assign pop  = valid_o && ready_i;
  assign push = inflight;
  // Occupancy credited with this cycle's pop keeps a read issued every cycle
  // under ready_i = 1 while still never exceeding two entries.
  assign occ   = count - {1'b0, pop} + {1'b0, inflight};
  assign issue = (state == ST_FETCH) && (occ < 2'd2);

  assign addr_ok   = 32'(wr_addr_i) < PKT_LEN;
  assign wr_commit = wr_en_i && addr_ok && (state == ST_IDLE);

  fc_param_mem #(
    .DEPTH  (PKT_LEN),
    .DATA_BW(W_BW),
    .ADDR_BW(MEM_AW)
  ) u_mem (
    .clk_i  (clk_i),
    .wr_en  (wr_commit),
    .wr_addr(wr_addr_i[MEM_AW-1:0]),
    .wr_data(wr_data_i),
    .rd_en  (issue),
    .rd_addr(rd_addr[MEM_AW-1:0]),
    .rd_data(mem_rd_data)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= 2'b00;
      bias_q        <= '0;
    end else begin
      if ((wr_en_i && !wr_commit) || (bias_wr_en_i && state != ST_IDLE))
        err_o <= 1'b1;
      if (bias_wr_en_i && state == ST_IDLE)
        bias_q <= bias_data_i;

      // The last tag travels with its read so it lands in the same FIFO slot.
      inflight      <= issue;
      inflight_last <= (rd_addr == LAST_ADDR);
      if (push) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_FETCH;
            rd_addr <= '0;
            busy_o  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            rd_addr <= rd_addr + ADDR_BW'(1);
            if (rd_addr == LAST_ADDR) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && last_o) begin
`ifdef FC_PARAM_AUTO_RESTART_EN
            state   <= ST_FETCH;
            rd_addr <= '0;
`else
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
`endif
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_param_streamer.sv
// Self-checking bench for fc_param_streamer (PKT_LEN=8); the reference is a plain
// array of expected weights plus an expected bias. Honours FC_PARAM_AUTO_RESTART_EN.
module tb_fc_param_streamer;

  localparam int I_BW    = 8;
  localparam int BIAS_BW = 16;
  localparam int NC      = 3;
  localparam int PKT_LEN = 8;
  localparam int ADDR_BW = 4;
  localparam int W_BW    = NC * I_BW;
  localparam int B_BW    = NC * BIAS_BW;

`ifdef FC_PARAM_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic               busy_o;
  logic               wr_en_i = 1'b0;
  logic [ADDR_BW-1:0] wr_addr_i = '0;
  logic [W_BW-1:0]    wr_data_i = '0;
  logic               bias_wr_en_i = 1'b0;
  logic [B_BW-1:0]    bias_data_i = '0;
  logic [W_BW-1:0]    data_w_o;
  logic [B_BW-1:0]    data_b_o;
  logic               valid_o;
  logic               last_o;
  logic               ready_i = 1'b0;
  logic               err_o;

  fc_param_streamer #(
    .I_BW       (I_BW),
    .BIAS_BW    (BIAS_BW),
    .NUM_CLASSES(NC),
    .PKT_LEN    (PKT_LEN),
    .ADDR_BW    (ADDR_BW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .bias_wr_en_i(bias_wr_en_i),
    .bias_data_i (bias_data_i),
    .data_w_o    (data_w_o),
    .data_b_o    (data_b_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [W_BW-1:0] exp_mem [PKT_LEN];
  logic [B_BW-1:0] exp_bias = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp_bias = '0;
  endtask

  // Only called while idle, so an in-range write must land in the model.
  task automatic write_w(input int addr, input logic [W_BW-1:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_BW'(addr);
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (addr < PKT_LEN) exp_mem[addr] = d;
  endtask

  task automatic write_b(input logic [B_BW-1:0] d);
    bias_wr_en_i = 1'b1;
    bias_data_i  = d;
    tick();
    bias_wr_en_i = 1'b0;
    exp_bias = d;
  endtask

  function automatic logic [W_BW-1:0] plan_word(input int k);
    return {8'(k + 2), 8'(k + 1), 8'(k)};
  endfunction

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; else random ready.
  // inject_at: beat index at which a write to addr 3 is attempted mid-packet.
  // abort_at: beat index at which rst_i is pulsed.
  task automatic stream(input string tag, input int mode, input int npkts,
                        input int inject_at, input int abort_at,
                        input bit wr_with_start, input logic [W_BW-1:0] start_wdata);
    int k, cyc, total;
    bit prev_stall, injected, rdy;
    logic [W_BW-1:0] prev_w;
    logic prev_last;
    k = 0; cyc = 0; total = npkts * PKT_LEN;
    prev_stall = 1'b0; injected = 1'b0; prev_w = '0; prev_last = 1'b0;

    start_i = 1'b1;
    if (wr_with_start) begin
      wr_en_i    = 1'b1;
      wr_addr_i  = '0;
      wr_data_i  = start_wdata;
      exp_mem[0] = start_wdata;
    end
    tick();
    start_i = 1'b0;
    wr_en_i = 1'b0;
    check({tag, " busy_after_start"}, busy_o, 1);
    check({tag, " valid_n1"}, valid_o, 0);
    tick();
    check({tag, " valid_n2_low"}, valid_o, 0);
    tick();
    check({tag, " valid_first"}, valid_o, 1);

    while (k < total && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_i = rdy;
      if (prev_stall) begin
        check({tag, " stall_hold_w"}, data_w_o, prev_w);
        check({tag, " stall_hold_last"}, last_o, prev_last);
      end
      check({tag, " busy_during"}, busy_o, 1);
      check({tag, " bias_hold"}, data_b_o, exp_bias);
      if (mode == 0 && npkts == 1) check({tag, " no_bubble"}, valid_o, 1);
      if (valid_o) begin
        check({tag, " beat_data"}, data_w_o, exp_mem[k % PKT_LEN]);
        check({tag, " beat_last"}, last_o, 64'((k % PKT_LEN) == PKT_LEN - 1));
      end
      if (k == inject_at && valid_o && !injected) begin
        wr_en_i   = 1'b1;
        wr_addr_i = ADDR_BW'(3);
        wr_data_i = ~exp_mem[3];
        injected  = 1'b1;
      end
      if (k == abort_at && valid_o) begin
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        ready_i = 1'b0;
        exp_bias = '0;
        check({tag, " abort_valid"}, valid_o, 0);
        check({tag, " abort_busy"}, busy_o, 0);
        check({tag, " abort_bias"}, data_b_o, 0);
        check({tag, " abort_w"}, data_w_o, 0);
        check({tag, " abort_err"}, err_o, 0);
        tick();
        check({tag, " abort_no_beats"}, valid_o, 0);
        return;
      end
      prev_stall = valid_o && !rdy;
      prev_w     = data_w_o;
      prev_last  = last_o;
      if (valid_o && rdy) k++;
      tick();
      cyc++;
      if (injected && wr_en_i) begin
        wr_en_i = 1'b0;
        check({tag, " err_set"}, err_o, 1);
      end
    end
    ready_i = 1'b0;
    check({tag, " beats_done"}, 64'(k), 64'(total));
    if (mode == 0 && npkts == 1) check({tag, " cycles"}, 64'(cyc), 64'(PKT_LEN));
    check({tag, " busy_end"}, busy_o, 64'(AUTO));
    check({tag, " valid_end"}, valid_o, 0);
    check({tag, " bias_after"}, data_b_o, exp_bias);
  endtask

  initial begin
    do_reset();
    check("rst valid", valid_o, 0);
    check("rst last", last_o, 0);
    check("rst busy", busy_o, 0);
    check("rst err", err_o, 0);
    check("rst data_w", data_w_o, 0);
    check("rst data_b", data_b_o, 0);

    for (int k = 0; k < PKT_LEN; k++) write_w(k, plan_word(k));
    write_b({16'h0300, 16'h0200, 16'h0100});

`ifdef FC_PARAM_AUTO_RESTART_EN
    stream("auto", 0, 3, -1, -1, 1'b0, '0);
    do_reset();
    check("auto rst busy", busy_o, 0);
    check("auto rst valid", valid_o, 0);
`else
    stream("plan_r1", 0, 1, -1, -1, 1'b0, '0);
    check("plan idle err", err_o, 0);
    stream("plan_stall", 1, 1, -1, -1, 1'b0, '0);
    stream("err_busy", 0, 1, 2, -1, 1'b0, '0);
    check("err sticky", err_o, 1);

    do_reset();
    check("err cleared", err_o, 0);
    write_b({16'h0300, 16'h0200, 16'h0100});
    write_w(PKT_LEN, W_BW'($urandom));
    check("err oob", err_o, 1);
    stream("oob_intact", 0, 1, -1, -1, 1'b0, '0);
    check("err oob sticky", err_o, 1);

    do_reset();
    write_b(B_BW'({$urandom, $urandom}));
    stream("abort", 0, 1, -1, 4, 1'b0, '0);
    write_b(B_BW'({$urandom, $urandom}));
    stream("after_abort", 0, 1, -1, -1, 1'b0, '0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < PKT_LEN; k++) write_w(k, W_BW'($urandom));
      write_b(B_BW'({$urandom, $urandom}));
      stream("rand", 2, 1, -1, -1, 1'b1, W_BW'($urandom));
    end
    check("rand err clean", err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_param_streamer.md
Name: fc_param_streamer

Overview:
- Producer for the weight/bias stream consumed by the fully-connected MAC stage.
- Holds one packet of per-class weight vectors in an internal synchronous-read memory, plus one per-class bias vector.
- On a start pulse, streams PKT_LEN weight beats with valid/ready/last handshaking.
- Holds the bias vector stable for the whole packet and beyond.

Parameters:
- I_BW, 8, weight element bitwidth
- BIAS_BW, 2*I_BW, bias element bitwidth
- NUM_CLASSES, 3, weight/bias elements per beat
- PKT_LEN, 208, beats per packet (>= 2)
- ADDR_BW, $clog2(PKT_LEN), memory address width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  begin streaming one packet; sampled only in IDLE
- busy_o  out  1  high in any state other than IDLE
- wr_en_i  in  1  weight memory write strobe
- wr_addr_i  in  ADDR_BW  weight write address
- wr_data_i  in  NUM_CLASSES*I_BW  packed weight vector, class i at [(i+1)*I_BW-1 : i*I_BW]
- bias_wr_en_i  in  1  bias register write strobe
- bias_data_i  in  NUM_CLASSES*BIAS_BW  packed bias vector, same packing as weights
- data_w_o  out  NUM_CLASSES*I_BW  streamed weight beat
- data_b_o  out  NUM_CLASSES*BIAS_BW  bias vector, static per packet
- valid_o  out  1  beat valid
- last_o  out  1  final beat of packet, qualified by valid_o
- ready_i  in  1  downstream accepts beat when valid_o && ready_i
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset: one clock, synchronous, active-high (clk_i, rst_i).
  - Reset values: state IDLE; valid_o, last_o, busy_o, err_o = 0; data_w_o, data_b_o = 0; FIFO empty; counters 0.
  - Memory contents are not reset.
  - Reset mid-packet aborts immediately. The next cycle shows valid_o = 0 and no further beats.
- FSM states:
  - IDLE: start_i = 1 moves to FETCH; rd_addr cleared to 0.
  - FETCH: issues reads at rd_addr, which increments per issue. Moves to DRAIN after issuing address PKT_LEN-1.
  - DRAIN: waits for the last beat's handshake, then returns to IDLE.
- Read pipeline:
  - Memory read latency is 1 cycle. Read data enters a 2-entry output FIFO.
  - A read is issued only when (FIFO occupancy + in-flight reads) < 2. This gives no overflow and full throughput.
- Output:
  - valid_o = FIFO non-empty. data_w_o and last_o come from the FIFO head.
  - last_o is 1 only on the beat read from address PKT_LEN-1.
  - While valid_o && !ready_i: data_w_o and last_o are held stable.
- Latency and throughput:
  - start_i sampled at edge N: valid_o first high after edge N+2.
  - With ready_i held at 1: exactly PKT_LEN consecutive valid cycles, last_o on the final one.
  - busy_o falls the cycle after the last handshake. start_i is accepted in that same cycle, giving back-to-back packets with a 2-cycle bubble.
- Bias:
  - data_b_o is the bias register and never changes while busy_o = 1.
  - It stays valid after the packet, because the consumer applies bias several cycles after last.
- Writes:
  - wr_en_i and bias_wr_en_i take effect only in IDLE.
  - Writes in IDLE in the same cycle as start_i commit before the first read, so the new data is streamed.
  - Error conditions set err_o; err_o clears only on rst_i. Each erroring write is dropped:
    - a write strobe while busy_o = 1;
    - wr_addr_i >= PKT_LEN.
- start_i while busy_o = 1 is ignored. It does not set err_o.

Optional Feature:
- Macro: FC_PARAM_AUTO_RESTART_EN.
- Defined: after the last handshake the FSM returns to FETCH with rd_addr = 0 instead of IDLE. Packets repeat continuously until rst_i. busy_o stays high, so writes error.
- Undefined: single packet per start_i, as described under Behaviour.

Decomposition:
- Shared package fc_pkg holds:
  - I_BW, BIAS_BW, NUM_CLASSES, PKT_LEN defaults;
  - FSM state encoding typedef (IDLE=0, FETCH=1, DRAIN=2);
  - packed weight/bias vector width constants, also used by the MAC stage.
- One natural sub-module: fc_param_mem, a PKT_LEN x NUM_CLASSES*I_BW single-write-port, synchronous-read RAM with 1-cycle latency.
- FIFO and FSM stay in the top module.

Test Plan:
- Load addr k with {k+2, k+1, k} (8-bit each); bias {16'h0300, 16'h0200, 16'h0100}; PKT_LEN=8; pulse start_i; ready_i=1 -> 8 consecutive beats with data_w_o = {k+2, k+1, k} for k=0..7; last_o only on k=7; valid_o first high 2 cycles after start; busy_o low the cycle after.
- Same load, ready_i toggled 1,0,0,1 repeating -> beats k=0..7 in order, none dropped or duplicated, data_w_o/last_o stable during every stall cycle.
- wr_en_i at addr 3 while streaming beat 2 -> err_o=1 from the next cycle; beat 3 still shows the old value; err_o stays 1 until rst_i.
- wr_addr_i=8 with PKT_LEN=8 in IDLE -> err_o=1; memory unchanged (verified by streaming).
- rst_i asserted at beat 4 -> the next cycle has valid_o=0, busy_o=0, data_b_o=0; a new start_i streams from k=0 with memory intact but bias reloaded.
- With FC_PARAM_AUTO_RESTART_EN and ready_i=1 -> beat sequence 0..7,0..7,... with last_o every 8th valid beat; busy_o never drops.
